// File: rtl/cache_ctrl_plru.sv
// Set-associative cache controller: tag/valid/tree-PLRU storage, lookup, miss refill and flush.
// state  | meaning
// IDLE   | ready for a request or flush
// LOOKUP | compare latched tag against the set; hit completes, miss picks a victim
// REFILL | memory line requested, waiting for mem_valid
// FLUSH  | clearing one set per cycle
module cache_ctrl_plru #(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4,
  parameter int BLOCK_SIZE = 32,
  localparam int OFS = $clog2(BLOCK_SIZE/4),
  localparam int SET = $clog2(NUM_SETS),
  localparam int WAY = $clog2(NUM_WAYS),
  localparam int TAG = ADDR_SIZE - SET - OFS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  output logic                 cpu_ready,
  output logic                 cpu_done,
  output logic                 cpu_hit,
  input  logic                 flush,
  output logic [WAY-1:0]       way,
  output logic [SET-1:0]       set,
  output logic [TAG-1:0]       tag,
  output logic                 data_we,
  output logic                 refill,
  output logic                 mem_req,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_valid
);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [TAG-1:0]      tag_q;
  logic [SET-1:0]      set_q;
  logic [SET-1:0]      fcnt_q;
  logic                we_q;
  logic                refilled_q;
  logic [WAY-1:0]      way_q;
  logic [WAY-1:0]      victim_q;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];
  logic [TAG-1:0]      tag_mem [NUM_SETS][NUM_WAYS];

  logic                hit;
  logic [WAY-1:0]      hit_way;
  logic                inv_found;
  logic [WAY-1:0]      inv_way;
  logic [WAY-1:0]      plru_way;
  logic [WAY-1:0]      victim;
  logic [NUM_WAYS-2:0] plru_row;
  logic                pb;
  int                  pnode;

  // The line offset never reaches the controller's decisions.
  logic unused_ofs;
  assign unused_ofs = ^cpu_addr[OFS-1:0];

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] row,
                                                     input logic [WAY-1:0] w);
    int   node;
    logic b;
    plru_touch = row;
    node = 0;
    for (int l = 0; l < WAY; l++) begin
      b = w[WAY-1-l];
      for (int n = 0; n < NUM_WAYS-1; n++)
        if (n == node) plru_touch[n] = ~b;
      node = 2*node + 1 + int'(b);
    end
  endfunction

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = NUM_WAYS-1; i >= 0; i--) begin
      if (valid_q[set_q][i] && tag_mem[set_q][i] == tag_q) begin
        hit     = 1'b1;
        hit_way = WAY'(i);
      end
      if (!valid_q[set_q][i]) begin
        inv_found = 1'b1;
        inv_way   = WAY'(i);
      end
    end
    plru_row = plru_q[set_q];
    plru_way = '0;
    pnode    = 0;
    pb       = 1'b0;
    for (int l = 0; l < WAY; l++) begin
      pb = 1'b0;
      for (int n = 0; n < NUM_WAYS-1; n++)
        if (n == pnode) pb = plru_row[n];
      plru_way[WAY-1-l] = pb;
      pnode = 2*pnode + 1 + int'(pb);
    end
    victim = inv_found ? inv_way : plru_way;
  end

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    cpu_hit   = 1'b0;
    data_we   = 1'b0;
    refill    = 1'b0;
    mem_req   = 1'b0;
    way       = way_q;
    case (state_q)
      S_IDLE: begin
        cpu_ready = 1'b1;
        if (flush)        state_d = S_FLUSH;
        else if (cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_done = 1'b1;
          cpu_hit  = ~refilled_q;
          way      = hit_way;
          data_we  = we_q;
          state_d  = S_IDLE;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req = 1'b1;
        if (mem_valid) begin
          data_we = 1'b1;
          refill  = 1'b1;
          way     = victim_q;
          state_d = S_LOOKUP;
        end
      end
      S_FLUSH: if (fcnt_q == SET'(NUM_SETS-1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      set_q      <= '0;
      fcnt_q     <= '0;
      we_q       <= 1'b0;
      refilled_q <= 1'b0;
      way_q      <= '0;
      victim_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      way_q   <= way;
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            fcnt_q <= '0;
          end else if (cpu_req) begin
            {tag_q, set_q} <= cpu_addr[ADDR_SIZE-1:OFS];
            we_q           <= cpu_we;
            refilled_q     <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (hit) plru_q[set_q] <= plru_touch(plru_q[set_q], hit_way);
          else     victim_q      <= victim;
        end
        S_REFILL: begin
          if (mem_valid) begin
            valid_q[set_q][victim_q] <= 1'b1;
            refilled_q               <= 1'b1;
          end
        end
        S_FLUSH: begin
          valid_q[fcnt_q] <= '0;
          plru_q[fcnt_q]  <= '0;
          fcnt_q          <= fcnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag storage carries no reset; valid bits alone decide whether an entry counts.
  always_ff @(posedge clk) begin
    if (rstn && state_q == S_REFILL && mem_valid)
      tag_mem[set_q][victim_q] <= tag_q;
  end

  assign set      = set_q;
  assign tag      = tag_q;
  assign mem_addr = {tag_q, set_q, {OFS{1'b0}}};

endmodule

// File: tb/tb_cache_ctrl_plru.sv
// Bench for cache_ctrl_plru: directed scenarios plus random traffic against a set/way/tree model.
module tb_cache_ctrl_plru;
  localparam int NS = 16, NW = 4, OFS = 3, SW = 4;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0, mem_valid = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready, cpu_done, cpu_hit, data_we, refill, mem_req;
  logic [1:0]  way;
  logic [3:0]  set;
  logic [24:0] tag;
  logic [31:0] mem_addr;

  int checks = 0, errors = 0;

  cache_ctrl_plru dut (
    .clk(clk), .rstn(rstn), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .flush(flush),
    .way(way), .set(set), .tag(tag), .data_we(data_we), .refill(refill),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  // Reference: per-set valid/tag arrays and a binary tree of "victim side" bits.
  bit m_valid [NS][NW];
  int m_tag   [NS][NW];
  bit m_plru  [NS][NW];

  function automatic void model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin m_valid[s][w] = 0; m_plru[s][w] = 0; end
  endfunction

  function automatic int model_find(int s, int t);
    for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int model_victim(int s);
    int lo, hi, node;
    for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
    lo = 0; hi = NW; node = 0;
    while (hi - lo > 1) begin
      if (m_plru[s][node]) begin lo = (lo + hi) / 2; node = 2*node + 2; end
      else                 begin hi = (lo + hi) / 2; node = 2*node + 1; end
    end
    return lo;
  endfunction

  function automatic void model_touch(int s, int w);
    int lo, hi, mid, node;
    lo = 0; hi = NW; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_plru[s][node] = 1; node = 2*node + 1; hi = mid; end
      else         begin m_plru[s][node] = 0; node = 2*node + 2; lo = mid; end
    end
  endfunction

  function automatic int model_update(logic [31:0] a);
    int s, t, w;
    s = int'((a >> OFS) % NS);
    t = int'(a >> (OFS + SW));
    w = model_find(s, t);
    if (w < 0) begin
      w = model_victim(s);
      m_valid[s][w] = 1;
      m_tag[s][w] = t;
    end
    model_touch(s, w);
    return w;
  endfunction

  // Observations of the most recent transaction.
  bit          r_done, r_hit, r_dwe, r_refill, r_mreq, r_stable;
  int          r_way, r_lat, r_wr_way, r_wr_set;
  logic [31:0] r_maddr;
  int          fl_low;
  bit          fl_done_seen;

  task automatic access(input logic [31:0] a, input logic we, input int d);
    int rc;
    r_done = 0; r_hit = 0; r_dwe = 0; r_refill = 0; r_mreq = 0; r_stable = 1;
    r_way = -1; r_lat = 0; r_wr_way = -1; r_wr_set = -1; r_maddr = '0; rc = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = a;
    @(negedge clk);
    cpu_req = 0; cpu_we = 0;
    for (int c = 1; c <= 100; c++) begin
      r_lat = c;
      if (cpu_done) begin
        r_done = 1; r_hit = cpu_hit; r_way = int'(way); r_dwe = data_we; r_refill = refill;
        break;
      end
      if (mem_req) begin
        if (!r_mreq) r_maddr = mem_addr;
        else if (mem_addr !== r_maddr) r_stable = 0;
        r_mreq = 1;
        rc++;
        if (rc == d + 1) begin
          mem_valid = 1;
          #1;
          if (data_we && refill) begin r_wr_way = int'(way); r_wr_set = int'(set); end
        end
      end
      @(negedge clk);
      mem_valid = 0;
    end
  endtask

  task automatic do_flush(input bit with_req);
    @(negedge clk);
    flush = 1; cpu_req = with_req; cpu_addr = 32'h40;
    @(negedge clk);
    flush = 0; cpu_req = 0;
    fl_low = 0; fl_done_seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (cpu_ready) break;
      if (cpu_done) fl_done_seen = 1;
      fl_low++;
      @(negedge clk);
    end
    model_clear();
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", cpu_ready); end
    checks++; if ({cpu_done, cpu_hit, data_we, refill, mem_req} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {cpu_done, cpu_hit, data_we, refill, mem_req}); end
    checks++; if ({way, set, tag} !== '0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_regs: way %0d set %0d tag %0h mem_addr %0h want all 0", way, set, tag, mem_addr); end
    rstn = 1;
    model_clear();
  endtask

  task automatic test_miss_refill();
    int w;
    access(32'h40, 1'b0, 2);
    w = model_update(32'h40);
    checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL miss_timeout: no cpu_done"); end
    checks++; if (r_maddr !== 32'h40 || !r_mreq) begin errors++; $display("FAIL miss_mem_addr: got %0h want 40", r_maddr); end
    checks++; if (r_wr_way !== 0 || r_wr_set !== 8) begin errors++; $display("FAIL miss_refill_write: way %0d set %0d want way 0 set 8", r_wr_way, r_wr_set); end
    checks++; if (r_hit !== 1'b0 || r_way !== w) begin errors++; $display("FAIL miss_done: hit %0b way %0d want hit 0 way %0d", r_hit, r_way, w); end
    checks++; if (r_lat !== 5 || !r_stable) begin errors++; $display("FAIL miss_latency: got %0d stable %0b want 5 stable 1", r_lat, r_stable); end
  endtask

  task automatic test_hit();
    @(negedge clk);
    mem_valid = 1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (data_we !== 1'b0 || refill !== 1'b0 || cpu_ready !== 1'b1) begin errors++; $display("FAIL idle_mem_valid: data_we %0b refill %0b ready %0b want 0 0 1", data_we, refill, cpu_ready); end
    end
    mem_valid = 0;
    access(32'h44, 1'b0, 0);
    void'(model_update(32'h44));
    checks++; if (r_done !== 1'b1 || r_lat !== 1) begin errors++; $display("FAIL hit_latency: done %0b lat %0d want 1 1", r_done, r_lat); end
    checks++; if (r_hit !== 1'b1 || r_way !== 0 || r_mreq !== 1'b0) begin errors++; $display("FAIL hit_result: hit %0b way %0d mem_req %0b want 1 0 0", r_hit, r_way, r_mreq); end
  endtask

  task automatic test_plru_fill();
    logic [31:0] addrs [3];
    addrs[0] = 32'hC0; addrs[1] = 32'h140; addrs[2] = 32'h1C0;
    for (int i = 0; i < 3; i++) begin
      access(addrs[i], 1'b0, i);
      void'(model_update(addrs[i]));
      checks++; if (r_wr_way !== i + 1 || r_hit !== 1'b0) begin errors++; $display("FAIL fill_way%0d: got %0d want %0d", i + 1, r_wr_way, i + 1); end
    end
    access(32'h40, 1'b0, 0);
    void'(model_update(32'h40));
    checks++; if (r_hit !== 1'b1 || r_way !== 0) begin errors++; $display("FAIL fill_rehit: hit %0b way %0d want 1 0", r_hit, r_way); end
    access(32'h240, 1'b0, 1);
    void'(model_update(32'h240));
    checks++; if (r_wr_way !== 2 || r_way !== 2) begin errors++; $display("FAIL plru_victim: got %0d want 2", r_wr_way); end
    access(32'hC0, 1'b0, 0);
    void'(model_update(32'hC0));
    checks++; if (r_hit !== 1'b1 || r_way !== 1) begin errors++; $display("FAIL plru_keep_way1: hit %0b way %0d want 1 1", r_hit, r_way); end
  endtask

  task automatic test_store_hit();
    access(32'hC4, 1'b1, 0);
    void'(model_update(32'hC4));
    checks++; if ({r_done, r_hit, r_dwe, r_refill} !== 4'b1110 || r_way !== 1) begin errors++; $display("FAIL store_hit: done/hit/we/refill %b way %0d want 1110 way 1", {r_done, r_hit, r_dwe, r_refill}, r_way); end
  endtask

  task automatic test_flush();
    do_flush(1'b1);
    checks++; if (fl_low !== NS || fl_done_seen) begin errors++; $display("FAIL flush_busy: not-ready cycles %0d done_seen %0b want %0d 0", fl_low, fl_done_seen, NS); end
    access(32'h40, 1'b0, 0);
    void'(model_update(32'h40));
    checks++; if (r_hit !== 1'b0 || !r_mreq || r_wr_way !== 0) begin errors++; $display("FAIL flush_remiss: hit %0b mem_req %0b way %0d want 0 1 0", r_hit, r_mreq, r_wr_way); end
  endtask

  task automatic test_reset_refill();
    @(negedge clk);
    cpu_req = 1; cpu_addr = 32'hA58;
    @(negedge clk);
    cpu_req = 0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_refill_pre: mem_req %0b want 1", mem_req); end
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_refill_abort: mem_req %0b ready %0b want 0 1", mem_req, cpu_ready); end
    model_clear();
    access(32'hA58, 1'b0, 0);
    void'(model_update(32'hA58));
    checks++; if (r_hit !== 1'b0 || !r_mreq || !r_done) begin errors++; $display("FAIL rst_refill_remiss: hit %0b mem_req %0b done %0b want 0 1 1", r_hit, r_mreq, r_done); end
  endtask

  task automatic test_random();
    int sets [4];
    int s, t, d, ew, ev;
    bit we;
    logic [31:0] a;
    sets[0] = 0; sets[1] = 3; sets[2] = 8; sets[3] = 15;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_flush(1'b0);
        checks++; if (fl_low !== NS) begin errors++; $display("FAIL rnd_flush: not-ready cycles %0d want %0d", fl_low, NS); end
        continue;
      end
      s = sets[$urandom_range(0, 3)];
      t = int'($urandom_range(0, 5));
      d = int'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      a = (32'(t) << (OFS + SW)) | (32'(s) << OFS) | 32'($urandom_range(0, 7));
      ew = model_find(s, t);
      ev = (ew < 0) ? model_victim(s) : -1;
      access(a, we, d);
      void'(model_update(a));
      checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL rnd_timeout: addr %0h", a); end
      checks++; if (r_hit !== (ew >= 0)) begin errors++; $display("FAIL rnd_hit: addr %0h got %0b want %0b", a, r_hit, ew >= 0); end
      checks++; if (r_dwe !== we || r_refill !== 1'b0) begin errors++; $display("FAIL rnd_done_write: data_we %0b refill %0b want %0b 0", r_dwe, r_refill, we); end
      if (ew >= 0) begin
        checks++; if (r_way !== ew || r_lat !== 1 || r_mreq) begin errors++; $display("FAIL rnd_hit_way: way %0d lat %0d mem_req %0b want %0d 1 0", r_way, r_lat, r_mreq, ew); end
      end else begin
        checks++; if (r_wr_way !== ev || r_way !== ev) begin errors++; $display("FAIL rnd_victim: addr %0h got %0d want %0d", a, r_wr_way, ev); end
        checks++; if (r_maddr !== (a & ~32'h7) || !r_stable || r_lat !== d + 3) begin errors++; $display("FAIL rnd_refill: mem_addr %0h lat %0d want %0h %0d", r_maddr, r_lat, a & ~32'h7, d + 3); end
        checks++; if (r_wr_set !== s) begin errors++; $display("FAIL rnd_set: got %0d want %0d", r_wr_set, s); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_plru_fill();
    test_store_hit();
    test_flush();
    test_reset_refill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
